seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low (rst==0 sampled at a rising clk edge resets the block).
REQ-004 start  input  1  request a division; sampled only when busy==0.
REQ-005 dividend  input  WIDTH  unsigned numerator (op1 of the DIV operator).
REQ-006 divisor  input  WIDTH  unsigned denominator (op2 of the DIV operator).
REQ-007 busy  output  1  high while an accepted division is iterating.
REQ-008 done  output  1  single-cycle pulse; quotient/remainder/div_by_zero valid.
REQ-009 quotient  output  WIDTH  unsigned floor(dividend/divisor); drives the datapath result for DIV.
REQ-010 remainder  output  WIDTH  dividend mod divisor.
REQ-011 div_by_zero  output  1  set when the accepted divisor was 0.

Function
REQ-012 The block SHALL implement a restoring shift-subtract divider, one quotient bit per clock, MSB first.
REQ-013 States SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-014 IDLE or DONE with start==1 at edge E0 SHALL latch dividend and divisor, clear the iteration counter, and enter CALC (divisor!=0) or DONE (divisor==0).
REQ-015 CALC SHALL perform exactly WIDTH iterations at edges E1..E_WIDTH; the last iteration SHALL enter DONE.
REQ-016 busy SHALL be 1 exactly in CALC (from E0 to E_WIDTH).
REQ-017 done SHALL be 1 exactly in DONE, for one cycle, then return to IDLE unless start is sampled.
REQ-018 Normal latency: done visible in the cycle after E_WIDTH (WIDTH+1 edges after start was sampled).
REQ-019 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold until the next DONE entry or reset.
REQ-020 Divisor 0: quotient = all ones, remainder = latched dividend, div_by_zero = 1, done visible in the cycle after E0.
REQ-021 Non-zero divisor: div_by_zero SHALL be 0 in the DONE cycle.
REQ-022 start while busy==1 SHALL be ignored; operand changes during CALC SHALL NOT affect the result.
REQ-023 start sampled in DONE SHALL be accepted (back-to-back operation with no IDLE gap).
REQ-024 Partial remainder SHALL be WIDTH+1 bits to hold the shift carry; no other internal overflow is possible.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 rst==0 at a clk edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-027 Reset during CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-028 rst==0 SHALL take priority over a simultaneous start.

Structure
REQ-029 The shared calculator package SHALL hold WIDTH's default, the state encoding (IDLE, CALC, DONE), and the operator codes ADD=0, SUB=1, MULT=2, DIV=3.
REQ-030 One combinational sub-module, div_step, SHALL compute a single shift-compare-subtract step (partial remainder, next dividend bit -> new remainder, quotient bit); the FSM, counter and registers stay in seq_divider.

Verification
REQ-031 100/7, WIDTH=8 -> done 9 edges after start; quotient=14, remainder=2, div_by_zero=0; busy high for 8 cycles.
REQ-032 7/100 -> quotient=0, remainder=7; 255/1 -> quotient=255, remainder=0; 255/255 -> quotient=1, remainder=0.
REQ-033 50/0 -> done in the cycle after start, quotient=255, remainder=50, div_by_zero=1, busy never high.
REQ-034 Start 200/3, rst=0 at E4, then release -> no done, all outputs 0; next start 9/2 -> quotient=4, remainder=1.
REQ-035 Start 60/4, then change operands to 9/9 and pulse start during CALC -> ignored, quotient=15, remainder=0.
REQ-036 Start 60/4, then start 17/5 in the DONE cycle -> second done exactly 9 edges later with quotient=3, remainder=2; outputs hold 15/0 in between.

Source files
------------

// File: rtl/seq_divider_pkg.sv
//------------------------------------------------------------------------------
// Module  : seq_divider_pkg
// Brief   : Shared calculator definitions: default width, FSM states, opcodes.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_divider_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MULT = 2'd2,
    DIV  = 2'd3
  } op_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
//------------------------------------------------------------------------------
// Module  : div_step
// Brief   : One restoring shift-compare-subtract step of the divider.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The shifted partial remainder needs one extra bit for the carry; once the
  // subtraction happens the true result is below the divisor, so W bits hold it.
  always_comb begin
    w_shift = {rem_in, dvd_bit};
    w_diff  = w_shift[WIDTH-1:0] - divisor;
    q_bit   = (w_shift >= {1'b0, divisor});
    rem_out = q_bit ? w_diff : w_shift[WIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module  : seq_divider
// Brief   : Unsigned restoring sequential divider, one quotient bit per clock.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                c_cnt_w     = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_prem;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_by_zero;
  logic               w_busy_next;
  logic               w_done_next;
  logic               w_q_bit;
  logic [WIDTH-1:0]   w_prem_next;
  logic [WIDTH-1:0]   w_dvd_next;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (r_prem),
    .dvd_bit (r_dvd[WIDTH-1]),
    .divisor (r_dvs),
    .rem_out (w_prem_next),
    .q_bit   (w_q_bit)
  );

  // Quotient bits shift in behind the dividend bits being consumed.
  assign w_dvd_next = (r_dvd << 1) | WIDTH'(w_q_bit);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_state_next = (divisor == '0) ? DONE : CALC;
        else       w_state_next = IDLE;
      end
      CALC: begin
        if (r_cnt == c_last_iter) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Flags are registered from the next state so they align with r_state.
  always_comb begin
    w_busy_next = (w_state_next == CALC);
    w_done_next = (w_state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_prem        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
            r_cnt  <= '0;
            if (divisor == '0) begin
              r_quotient    <= '1;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          r_dvd  <= w_dvd_next;
          r_prem <= w_prem_next;
          r_cnt  <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last_iter) begin
            r_quotient    <= w_dvd_next;
            r_remainder   <= w_prem_next;
            r_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire
